pair_stream_gen: RTL



---
 rtl/psg_pkg.sv | 30 +++
 rtl/psg_lfsr.sv | 29 ++
 rtl/pair_stream_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// ---------------------------------------------------------------------------
// psg_pkg
// Shared types and constants for the pair stream generator.
//   psg_state_t : FSM states (IDLE, EQ, GAP, DONE); EQ and GAP together form RUN
//   LFSR_SEED   : reset value of the optional pseudo-random value source
//   LFSR_TAPS   : Fibonacci tap mask for polynomial taps 8,6,5,4
//   PSG_W/PSG_CW: default operand width and count width
//   lfsr_next() : one Fibonacci shift of the 8-bit LFSR
// ---------------------------------------------------------------------------
package psg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EQ   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } psg_state_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int PSG_W  = 3;
    localparam int PSG_CW = 8;

    // Shift left; the new LSB is the XOR of the tapped bits (7,5,4,3).
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/psg_lfsr.sv
// ---------------------------------------------------------------------------
// psg_lfsr
// 8-bit Fibonacci LFSR used as the pseudo-random value source of
// pair_stream_gen. Only present when PSG_LFSR_EN is defined.
//   clk   : system clock
//   reset : asynchronous active-high reset, loads LFSR_SEED
//   step  : advance the register by one shift this edge
//   q     : current LFSR state
// ---------------------------------------------------------------------------
`ifdef PSG_LFSR_EN
module psg_lfsr
    import psg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule
`endif

// File: rtl/pair_stream_gen.sv
// ---------------------------------------------------------------------------
// pair_stream_gen
// Drives a registered stream of W-bit operand pairs containing exactly
// `target` equal pairs, each followed (except the last) by `gap` unequal
// filler pairs. Optional macro PSG_LFSR_EN switches the value source from an
// incrementing counter to the low bits of an 8-bit LFSR.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   start  : one-cycle request, honoured only in IDLE
//   target : number of equal pairs, latched on an accepted start
//   gap    : filler pairs after each equal pair but the last, latched on start
//   x, y   : current operand pair
//   valid  : x/y carry a pair this cycle
//   busy   : high while the FSM is in EQ or GAP
//   done   : one-cycle pulse in the cycle after the last pair
//   sent   : equal pairs emitted so far in this run
// ---------------------------------------------------------------------------
module pair_stream_gen
    import psg_pkg::*;
#(
    parameter int W  = PSG_W,
    parameter int CW = PSG_CW
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] target,
    input  logic [1:0]    gap,
    output logic [W-1:0]  x,
    output logic [W-1:0]  y,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] sent
);

    localparam logic [W-1:0] LSB_ONE = W'(1);

    psg_state_t    state;
    logic [CW-1:0] target_q;
    logic [1:0]    gap_q;
    logic [1:0]    gap_cnt;
    logic [W-1:0]  v;
    logic          emit;

    // The state names what is currently on x/y, so a new pair is registered
    // on every edge that starts a run, follows an equal pair that was not the
    // last one, or follows a filler pair.
    assign emit = ((state == IDLE) && start && (target != '0)) ||
                  ((state == EQ) && (sent != target_q)) ||
                  (state == GAP);

`ifdef PSG_LFSR_EN
    logic [7:0] lfsr_q;

    psg_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (emit),
        .q     (lfsr_q)
    );

    assign v = lfsr_q[W-1:0];
`else
    logic [W-1:0] value_cnt;

    // Free-running value source; cleared by reset only, so consecutive runs
    // continue where the previous one stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_cnt <= '0;
        end else if (emit) begin
            value_cnt <= value_cnt + LSB_ONE;
        end
    end

    assign v = value_cnt;
`endif

    // sent already counts the equal pair on the outputs, so "sent == target"
    // in EQ means that pair was the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            target_q <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            x        <= '0;
            y        <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sent     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (target != '0) begin
                            target_q <= target;
                            gap_q    <= gap;
                            sent     <= CW'(1);
                            x        <= v;
                            y        <= v;
                            valid    <= 1'b1;
                            busy     <= 1'b1;
                            state    <= EQ;
                        end else begin
                            sent  <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                EQ: begin
                    if (sent == target_q) begin
                        x     <= '0;
                        y     <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (gap_q != 2'd0) begin
                        gap_cnt <= gap_q;
                        x       <= v;
                        y       <= v ^ LSB_ONE;
                        state   <= GAP;
                    end else begin
                        x    <= v;
                        y    <= v;
                        sent <= sent + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 2'd1) begin
                        x     <= v;
                        y     <= v;
                        sent  <= sent + 1'b1;
                        state <= EQ;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                        x       <= v;
                        y       <= v ^ LSB_ONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
